// File: rtl/mcu_bus_pkg.sv
// Shared types, constants and helpers for the 8051 external-memory bus slave.
package mcu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } bus_state_e;

    typedef enum logic [1:0] {
        RD_HOLD,
        RD_ROM,
        RD_RAM
    } rd_src_e;

    localparam logic SEL_CODE = 1'b0;
    localparam logic SEL_DATA = 1'b1;

    function automatic logic in_range(input logic [63:0] addr, input int unsigned depth);
        return addr < 64'(depth);
    endfunction

endpackage

// File: rtl/mcu_sp_ram.sv
// Synchronous RAM with one write port and one registered read port.
module mcu_sp_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_q;

    // Read and write in the same block: a same-edge collision returns the old word.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_q <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/mcu_bus_mem.sv
// External-memory slave: code ROM plus data RAM behind a ready handshake with wait states.
module mcu_bus_mem #(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       ADDR_W      = 16,
    parameter int unsigned       ROM_DEPTH   = 4096,
    parameter int unsigned       RAM_DEPTH   = 256,
    parameter int unsigned       WAIT_STATES = 0,
    parameter logic [DATA_W-1:0] FILL        = '1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [ADDR_W-1:0] i_addr_bus,
    input  logic              i_read_en,
    input  logic              i_write_en,
    input  logic              i_memory_select,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_ready,
    output logic              o_err,
    output logic              o_busy,
    input  logic              i_load_en,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [DATA_W-1:0] i_load_data
);
    import mcu_bus_pkg::*;

    localparam int unsigned ROM_AW   = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
    localparam int unsigned RAM_AW   = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    bus_state_e        r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_sel;
    logic              r_rd;
    logic              r_wr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_ready;
    logic              r_err;
    logic              r_busy;
    logic [DATA_W-1:0] r_hold;
    rd_src_e           r_src;

    logic              w_both;
    logic              w_in_range;
    logic              w_fault;
    logic              w_resp;
    logic              w_rom_re;
    logic              w_rom_we;
    logic              w_ram_re;
    logic              w_ram_we;
    logic [DATA_W-1:0] w_rom_q;
    logic [DATA_W-1:0] w_ram_q;

    assign w_both     = r_rd & r_wr;
    assign w_in_range = (r_sel == SEL_DATA) ? in_range(64'(r_addr), RAM_DEPTH)
                                            : in_range(64'(r_addr), ROM_DEPTH);
    assign w_fault    = w_both | (r_wr & (r_sel == SEL_CODE)) | ~w_in_range;

    // A reset on the RESP edge must suppress the access entirely.
    assign w_resp   = (r_state == RESP) & ~i_reset;
    assign w_rom_re = w_resp & r_rd & ~w_both & (r_sel == SEL_CODE) & w_in_range;
    assign w_ram_re = w_resp & r_rd & ~w_both & (r_sel == SEL_DATA) & w_in_range;
    assign w_ram_we = w_resp & r_wr & ~w_both & (r_sel == SEL_DATA) & w_in_range;
    assign w_rom_we = i_load_en & in_range(64'(i_load_addr), ROM_DEPTH);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_hold  <= '0;
            r_src   <= RD_HOLD;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_busy <= i_read_en | i_write_en;
                    if (i_read_en | i_write_en) begin
                        r_addr  <= i_addr_bus;
                        r_sel   <= i_memory_select;
                        r_wdata <= i_wdata;
                        r_rd    <= i_read_en;
                        r_wr    <= i_write_en;
                        if (WAIT_STATES > 0) begin
                            r_state <= WAIT;
                            r_cnt   <= CNT_INIT;
                        end else begin
                            r_state <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_ready <= 1'b1;
                    r_err   <= w_fault;
                    r_state <= IDLE;
                    if (w_both || (r_rd && !w_in_range)) begin
                        r_hold <= FILL;
                        r_src  <= RD_HOLD;
                    end else if (r_rd) begin
                        r_src <= (r_sel == SEL_DATA) ? RD_RAM : RD_ROM;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Memory read ports are registered at the RESP edge; r_src picks which one drives rdata.
    always_comb begin
        o_rdata = r_hold;
        unique case (r_src)
            RD_ROM:  o_rdata = w_rom_q;
            RD_RAM:  o_rdata = w_ram_q;
            default: o_rdata = r_hold;
        endcase
    end

    assign o_ready = r_ready;
    assign o_err   = r_err;
    assign o_busy  = r_busy;

    mcu_sp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (ROM_DEPTH),
        .AW     (ROM_AW)
    ) u_rom (
        .i_clk   (i_clk),
        .i_we    (w_rom_we),
        .i_waddr (i_load_addr[ROM_AW-1:0]),
        .i_wdata (i_load_data),
        .i_re    (w_rom_re),
        .i_raddr (r_addr[ROM_AW-1:0]),
        .o_rdata (w_rom_q)
    );

    mcu_sp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (RAM_DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_ram_we),
        .i_waddr (r_addr[RAM_AW-1:0]),
        .i_wdata (r_wdata),
        .i_re    (w_ram_re),
        .i_raddr (r_addr[RAM_AW-1:0]),
        .o_rdata (w_ram_q)
    );

endmodule

// File: tb/tb_mcu_bus_mem.sv
// Directed bench for mcu_bus_mem with two wait states.
module tb_mcu_bus_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr_bus;
    logic        read_en;
    logic        write_en;
    logic        memory_select;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        ready;
    logic        err;
    logic        busy;
    logic        load_en;
    logic [15:0] load_addr;
    logic [7:0]  load_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mcu_bus_mem #(
        .DATA_W      (8),
        .ADDR_W      (16),
        .ROM_DEPTH   (4096),
        .RAM_DEPTH   (256),
        .WAIT_STATES (2),
        .FILL        (8'hFF)
    ) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_addr_bus      (addr_bus),
        .i_read_en       (read_en),
        .i_write_en      (write_en),
        .i_memory_select (memory_select),
        .i_wdata         (wdata),
        .o_rdata         (rdata),
        .o_ready         (ready),
        .o_err           (err),
        .o_busy          (busy),
        .i_load_en       (load_en),
        .i_load_addr     (load_addr),
        .i_load_data     (load_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] a, input logic [7:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    // One access with the request dropped right after accept; waits a bounded time for ready.
    task automatic access(input logic rd, input logic wr, input logic sel, input logic [15:0] a,
                          input logic [7:0] d, output logic got, output int lat,
                          output logic [7:0] rd_o, output logic e_o);
        read_en = rd; write_en = wr; memory_select = sel; addr_bus = a; wdata = d;
        tick();
        read_en = 1'b0; write_en = 1'b0; addr_bus = 16'hFFFF; wdata = 8'h00;
        got = 1'b0; lat = 0; rd_o = 8'hxx; e_o = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ready === 1'b1) begin
                got = 1'b1; lat = i; rd_o = rdata; e_o = err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h exp 00", rdata); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    endtask

    task automatic test_rom_read_timing();
        load(16'h0003, 8'h60);
        read_en = 1'b1; memory_select = 1'b0; addr_bus = 16'h0003;
        tick();
        read_en = 1'b0; addr_bus = 16'h0123;
        for (int i = 0; i < 3; i++) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rom_busy_k%0d got %b exp 1", i, busy); end
            checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rom_ready_k%0d got %b exp 0", i, ready); end
            tick();
        end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rom_ready_k3 got %b exp 1", ready); end
        checks++; if (rdata !== 8'h60) begin errors++; $display("FAIL rom_rdata got %h exp 60", rdata); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rom_err got %b exp 0", err); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rom_busy_k3 got %b exp 1", busy); end
        tick();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rom_ready_k4 got %b exp 0", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rom_busy_k4 got %b exp 0", busy); end
    endtask

    task automatic test_ram_rw();
        logic got; int lat; logic [7:0] q; logic e;
        access(1'b0, 1'b1, 1'b1, 16'h0010, 8'h50, got, lat, q, e);
        checks++; if (got !== 1'b1 || lat != 3) begin errors++; $display("FAIL ram_wr_ready got %b lat %0d exp 1 lat 3", got, lat); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL ram_wr_err got %b exp 0", e); end
        checks++; if (q !== 8'h60) begin errors++; $display("FAIL ram_wr_rdata_held got %h exp 60", q); end
        access(1'b1, 1'b0, 1'b1, 16'h0010, 8'h00, got, lat, q, e);
        checks++; if (q !== 8'h50 || got !== 1'b1) begin errors++; $display("FAIL ram_rd_rdata got %h exp 50", q); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL ram_rd_err got %b exp 0", e); end
    endtask

    task automatic test_rom_write_fault();
        logic got; int lat; logic [7:0] q; logic e;
        access(1'b0, 1'b1, 1'b0, 16'h0003, 8'hAA, got, lat, q, e);
        checks++; if (got !== 1'b1 || e !== 1'b1) begin errors++; $display("FAIL romwr_err got ready %b err %b exp 1 1", got, e); end
        access(1'b1, 1'b0, 1'b0, 16'h0003, 8'h00, got, lat, q, e);
        checks++; if (q !== 8'h60 || e !== 1'b0) begin errors++; $display("FAIL romwr_keep got %h err %b exp 60 0", q, e); end
    endtask

    task automatic test_out_of_range();
        logic got; int lat; logic [7:0] q; logic e;
        access(1'b1, 1'b0, 1'b1, 16'h0100, 8'h00, got, lat, q, e);
        checks++; if (q !== 8'hFF || e !== 1'b1) begin errors++; $display("FAIL oor_data_rd got %h err %b exp FF 1", q, e); end
        access(1'b1, 1'b0, 1'b0, 16'h1000, 8'h00, got, lat, q, e);
        checks++; if (q !== 8'hFF || e !== 1'b1) begin errors++; $display("FAIL oor_code_rd got %h err %b exp FF 1", q, e); end
        access(1'b0, 1'b1, 1'b1, 16'h0000, 8'h44, got, lat, q, e);
        access(1'b0, 1'b1, 1'b1, 16'h0100, 8'h33, got, lat, q, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_data_wr_err got %b exp 1", e); end
        access(1'b1, 1'b0, 1'b1, 16'h0000, 8'h00, got, lat, q, e);
        checks++; if (q !== 8'h44) begin errors++; $display("FAIL oor_wr_dropped got %h exp 44", q); end
        access(1'b1, 1'b1, 1'b1, 16'h0010, 8'h99, got, lat, q, e);
        checks++; if (q !== 8'hFF || e !== 1'b1) begin errors++; $display("FAIL both_en got %h err %b exp FF 1", q, e); end
        access(1'b1, 1'b0, 1'b1, 16'h0010, 8'h00, got, lat, q, e);
        checks++; if (q !== 8'h50 || e !== 1'b0) begin errors++; $display("FAIL both_ram_keep got %h err %b exp 50 0", q, e); end
    endtask

    task automatic test_reset_mid_write();
        logic got; int lat; logic [7:0] q; logic e; int seen;
        access(1'b0, 1'b1, 1'b1, 16'h0020, 8'h11, got, lat, q, e);
        write_en = 1'b1; memory_select = 1'b1; addr_bus = 16'h0020; wdata = 8'h77;
        tick();
        write_en = 1'b0;
        tick();
        reset = 1'b1;
        seen = 0;
        load_en = 1'b1; load_addr = 16'h0007; load_data = 8'h9C;
        tick();
        load_en = 1'b0;
        if (ready === 1'b1) seen++;
        repeat (2) begin tick(); if (ready === 1'b1) seen++; end
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || err !== 1'b0 || rdata !== 8'h00) begin errors++; $display("FAIL rst_mid_outputs got busy %b err %b rdata %h exp 0 0 00", busy, err, rdata); end
        repeat (4) begin tick(); if (ready === 1'b1) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL rst_mid_no_ready got %0d ready cycles exp 0", seen); end
        access(1'b1, 1'b0, 1'b1, 16'h0020, 8'h00, got, lat, q, e);
        checks++; if (q !== 8'h11) begin errors++; $display("FAIL rst_mid_no_commit got %h exp 11", q); end
        access(1'b1, 1'b0, 1'b0, 16'h0007, 8'h00, got, lat, q, e);
        checks++; if (q !== 8'h9C) begin errors++; $display("FAIL load_in_reset got %h exp 9C", q); end
    endtask

    task automatic test_back_to_back();
        int lat1; int lat2;
        lat1 = 0; lat2 = 0;
        read_en = 1'b1; memory_select = 1'b1; addr_bus = 16'h0010;
        tick();
        for (int i = 1; i <= 20; i++) begin tick(); if (ready === 1'b1) begin lat1 = i; break; end end
        checks++; if (lat1 != 3 || rdata !== 8'h50) begin errors++; $display("FAIL b2b_first got lat %0d rdata %h exp 3 50", lat1, rdata); end
        tick();
        read_en = 1'b0;
        checks++; if (ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_reaccept got ready %b busy %b exp 0 1", ready, busy); end
        for (int i = 1; i <= 20; i++) begin tick(); if (ready === 1'b1) begin lat2 = i; break; end end
        checks++; if (lat2 != 3 || rdata !== 8'h50) begin errors++; $display("FAIL b2b_second got lat %0d rdata %h exp 3 50", lat2, rdata); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b exp 0", busy); end
    endtask

    task automatic test_preload_collision();
        logic got; int lat; logic [7:0] q; logic e;
        load(16'h0005, 8'h12);
        read_en = 1'b1; memory_select = 1'b0; addr_bus = 16'h0005;
        tick();
        read_en = 1'b0;
        repeat (2) tick();
        load_en = 1'b1; load_addr = 16'h0005; load_data = 8'h34;
        tick();
        load_en = 1'b0;
        checks++; if (ready !== 1'b1 || rdata !== 8'h12) begin errors++; $display("FAIL collide_old got ready %b rdata %h exp 1 12", ready, rdata); end
        load(16'h1005, 8'h56);
        access(1'b1, 1'b0, 1'b0, 16'h0005, 8'h00, got, lat, q, e);
        checks++; if (q !== 8'h34) begin errors++; $display("FAIL collide_new_oorload got %h exp 34", q); end
    endtask

    initial begin
        reset = 1'b1; addr_bus = '0; read_en = 1'b0; write_en = 1'b0; memory_select = 1'b0;
        wdata = '0; load_en = 1'b0; load_addr = '0; load_data = '0;
        #1;
        test_reset();
        test_rom_read_timing();
        test_ram_rw();
        test_rom_write_fault();
        test_out_of_range();
        test_reset_mid_write();
        test_back_to_back();
        test_preload_collision();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1);
    end

endmodule
